// File: rtl/compressor_tree_sequencer.sv
// compressor_tree_sequencer: reduces NUM_TERMS operands through one narrow carry-save tree,
// TERMS_PER_PASS new operands per cycle, returning the result carry-save and carry-propagated.
module compressor_tree_sequencer #(
   parameter int unsigned NUM_TERMS      = 16,
   parameter int unsigned TERMS_PER_PASS = 4,
   parameter int unsigned BIT_LEN        = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [NUM_TERMS*BIT_LEN-1:0]   in_terms,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [BIT_LEN-1:0]             out_C,
   output logic [BIT_LEN-1:0]             out_S,
   output logic [BIT_LEN-1:0]             out_sum,
   output logic                           busy
);
   localparam int unsigned NUM_PASSES = (NUM_TERMS + TERMS_PER_PASS - 1) / TERMS_PER_PASS;
   localparam int unsigned CNT_W      = $clog2(NUM_PASSES + 1);
   localparam int unsigned OPS_W      = NUM_TERMS * BIT_LEN;

   typedef enum logic [1:0] {IDLE, RUN, SUM, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   pass_cnt;
   logic [OPS_W-1:0]   ops;
   logic [BIT_LEN-1:0] acc_C;
   logic [BIT_LEN-1:0] acc_S;
   logic [BIT_LEN-1:0] tree_C;
   logic [BIT_LEN-1:0] tree_S;
   logic [BIT_LEN-1:0] maj;
   logic [BIT_LEN-1:0] chunk [TERMS_PER_PASS];

   // Operand window for the current pass; slots beyond the last operand read as zero.
   always_comb begin
      for (int i = 0; i < int'(TERMS_PER_PASS); i++) begin
         chunk[i] = '0;
         if ((32'(pass_cnt) * TERMS_PER_PASS + 32'(i)) < NUM_TERMS)
            chunk[i] = ops[(32'(pass_cnt) * TERMS_PER_PASS + 32'(i)) * BIT_LEN +: BIT_LEN];
      end
   end

   // 3:2 reduction of {acc_C, acc_S, chunk}; carries shifted past the MSB are dropped.
   always_comb begin
      tree_C = acc_C;
      tree_S = acc_S;
      maj    = '0;
      for (int i = 0; i < int'(TERMS_PER_PASS); i++) begin
         maj    = (tree_C & tree_S) | (tree_C & chunk[i]) | (tree_S & chunk[i]);
         tree_S = tree_C ^ tree_S ^ chunk[i];
         tree_C = maj << 1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         pass_cnt  <= '0;
         ops       <= '0;
         acc_C     <= '0;
         acc_S     <= '0;
         out_C     <= '0;
         out_S     <= '0;
         out_sum   <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  ops      <= in_terms;
                  acc_C    <= '0;
                  acc_S    <= '0;
                  pass_cnt <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               acc_C <= tree_C;
               acc_S <= tree_S;
               if (pass_cnt == CNT_W'(NUM_PASSES - 1)) begin
                  pass_cnt <= '0;
                  state    <= SUM;
               end else begin
                  pass_cnt <= pass_cnt + CNT_W'(1);
               end
            end
            SUM: begin
               out_C     <= acc_C;
               out_S     <= acc_S;
               out_sum   <= acc_C + acc_S;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
